// File: rtl/reg_write_if.sv
// Bus bundle between the writers and the shared-register arbiter:
// per-writer request/data in, one-hot acknowledge and register state out.
interface reg_write_if #(
  parameter int N = 4,
  parameter int M = 4
);
  localparam int IW = (M > 1) ? $clog2(M) : 1;

  logic [M-1:0]   req;
  logic [M*N-1:0] wdata;
  logic [M-1:0]   ack;
  logic [N-1:0]   q;
  logic [IW-1:0]  owner;
  logic           busy;

  modport master (output req, wdata, input ack, q, owner, busy);
  modport slave  (input req, wdata, output ack, q, owner, busy);
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting M writers access to one shared N-bit register
// through a 4-phase req/ack handshake (IDLE -> GRANT -> ACK -> IDLE).
module reg_write_arbiter #(
  parameter int N = 4,
  parameter int M = 4
) (
  input  logic        clk,
  input  logic        rst,
  reg_write_if.slave  bus
);
  localparam int IW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q,  last_d;
  logic [N-1:0]  q_q,     q_d;
  logic [M-1:0]  ack_q,   ack_d;

  logic [N-1:0]  wslice [M];
  logic [IW-1:0] pick;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    for (int i = 0; i < M; i++) begin
      wslice[i] = bus.wdata[i*N +: N];
    end
  end

  // Search starts just past the last completed winner and wraps to 0.
  always_comb begin
    pick  = last_q;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= M; k++) begin
      cand = IW'((int'(last_q) + k) % M);
      if (!found && bus.req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    q_d     = q_q;
    ack_d   = ack_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          owner_d = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // A withdrawn request aborts without writing or advancing rotation.
        if (bus.req[owner_q]) begin
          q_d            = wslice[owner_q];
          ack_d          = '0;
          ack_d[owner_q] = 1'b1;
          state_d        = ACK;
        end else begin
          state_d = IDLE;
        end
      end
      ACK: begin
        if (!bus.req[owner_q]) begin
          ack_d   = '0;
          last_d  = owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(M - 1);
      q_q     <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      q_q     <= q_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.q     = q_q;
  assign bus.ack   = ack_q;
  assign bus.owner = owner_q;
  assign bus.busy  = (state_q != IDLE);
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scenario bench for reg_write_arbiter with N=4, M=4 and a grant scoreboard.
module tb_reg_write_arbiter;
  typedef struct {
    logic [1:0] owner;
    logic [3:0] data;
  } exp_t;

  logic clk;
  logic rst;
  logic [3:0] wd [4];
  exp_t sb [$];
  exp_t e;
  int pass_cnt;
  int total_cnt;

  reg_write_if #(.N(4), .M(4)) bus ();

  reg_write_arbiter #(.N(4), .M(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.wdata = {wd[3], wd[2], wd[1], wd[0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (|bus.ack) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pop_exp(output exp_t x, output bit ok);
    ok = (sb.size() > 0);
    x.owner = '0;
    x.data  = '0;
    if (ok) x = sb.pop_front();
  endtask

  task automatic test_reset;
    bit ok;
    rst = 1'b0;
    bus.req = 4'b1111;
    wd[0] = 4'h3; wd[1] = 4'h4; wd[2] = 4'h5; wd[3] = 4'h6;
    repeat (3) @(negedge clk);
    total_cnt++; if (bus.q !== 4'h0) $display("FAIL reset_q: got %h want 0", bus.q); else pass_cnt++;
    total_cnt++; if (bus.ack !== 4'b0000) $display("FAIL reset_ack: got %b want 0000", bus.ack); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.owner !== 2'd0) $display("FAIL reset_owner: got %0d want 0", bus.owner); else pass_cnt++;
    sb.push_back('{owner: 2'd0, data: 4'h3});
    rst = 1'b1;
    @(negedge clk);
    total_cnt++; if (bus.owner !== 2'd0 || bus.busy !== 1'b1)
      $display("FAIL reset_first_grant: got owner %0d busy %b want owner 0 busy 1", bus.owner, bus.busy); else pass_cnt++;
    @(negedge clk);
    pop_exp(e, ok);
    total_cnt++; if (!ok || bus.ack !== (4'b0001 << e.owner) || bus.q !== e.data)
      $display("FAIL reset_first_write: got ack %b q %h want ack %b q %h", bus.ack, bus.q, 4'b0001 << e.owner, e.data); else pass_cnt++;
    bus.req = 4'b0000;
    @(negedge clk);
    total_cnt++; if (bus.busy !== 1'b0 || bus.ack !== 4'b0000)
      $display("FAIL reset_release: got busy %b ack %b want 0 0000", bus.busy, bus.ack); else pass_cnt++;
  endtask

  task automatic test_single_write;
    bit ok;
    wd[2] = 4'hA;
    bus.req = 4'b0100;
    sb.push_back('{owner: 2'd2, data: 4'hA});
    repeat (2) @(negedge clk);
    pop_exp(e, ok);
    total_cnt++; if (!ok || bus.q !== e.data) $display("FAIL single_q: got %h want %h", bus.q, e.data); else pass_cnt++;
    total_cnt++; if (bus.ack !== 4'b0100) $display("FAIL single_ack: got %b want 0100", bus.ack); else pass_cnt++;
    total_cnt++; if (bus.owner !== e.owner) $display("FAIL single_owner: got %0d want %0d", bus.owner, e.owner); else pass_cnt++;
    wd[2] = 4'h5;
    @(negedge clk);
    total_cnt++; if (bus.q !== 4'hA) $display("FAIL single_hold_q: got %h want a", bus.q); else pass_cnt++;
    bus.req = 4'b0000;
    @(negedge clk);
    total_cnt++; if (bus.ack !== 4'b0000 || bus.busy !== 1'b0 || bus.q !== 4'hA)
      $display("FAIL single_release: got ack %b busy %b q %h want 0000 0 a", bus.ack, bus.busy, bus.q); else pass_cnt++;
  endtask

  task automatic test_round_robin;
    bit ok;
    logic [1:0] w;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    wd[0] = 4'h1; wd[1] = 4'h2; wd[2] = 4'h3; wd[3] = 4'h4;
    for (int i = 0; i < 4; i++) sb.push_back('{owner: 2'(i), data: 4'(i + 1)});
    bus.req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_ack(ok);
      total_cnt++; if (!ok) $display("FAIL rr_timeout_%0d: got no ack want ack", t); else pass_cnt++;
      pop_exp(e, ok);
      total_cnt++; if (!ok || bus.owner !== e.owner || bus.ack !== (4'b0001 << e.owner) || bus.q !== e.data)
        $display("FAIL rr_grant_%0d: got owner %0d ack %b q %h want owner %0d ack %b q %h",
                 t, bus.owner, bus.ack, bus.q, e.owner, 4'b0001 << e.owner, e.data); else pass_cnt++;
      w = bus.owner;
      if (t == 4) begin
        bus.req = 4'b0000;
      end else begin
        bus.req[w] = 1'b0;
      end
      if (t == 0) begin
        wd[0] = 4'hE;
        sb.push_back('{owner: 2'd0, data: 4'hE});
      end
      @(negedge clk);
      total_cnt++; if (bus.ack !== 4'b0000) $display("FAIL rr_ack_fall_%0d: got %b want 0000", t, bus.ack); else pass_cnt++;
      if (t != 4) bus.req[w] = 1'b1;
    end
  endtask

  task automatic test_wrap;
    bit ok;
    wd[3] = 4'h7;
    bus.req = 4'b1000;
    sb.push_back('{owner: 2'd3, data: 4'h7});
    wait_ack(ok);
    pop_exp(e, ok);
    total_cnt++; if (!ok || bus.owner !== e.owner || bus.q !== e.data)
      $display("FAIL wrap_setup: got owner %0d q %h want owner %0d q %h", bus.owner, bus.q, e.owner, e.data); else pass_cnt++;
    bus.req = 4'b0000;
    @(negedge clk);
    wd[0] = 4'h5; wd[3] = 4'h9;
    bus.req = 4'b1001;
    sb.push_back('{owner: 2'd0, data: 4'h5});
    sb.push_back('{owner: 2'd3, data: 4'h9});
    wait_ack(ok);
    pop_exp(e, ok);
    total_cnt++; if (!ok || bus.owner !== e.owner || bus.ack !== (4'b0001 << e.owner) || bus.q !== e.data)
      $display("FAIL wrap_first: got owner %0d ack %b q %h want owner %0d q %h", bus.owner, bus.ack, bus.q, e.owner, e.data); else pass_cnt++;
    bus.req[0] = 1'b0;
    wait_ack(ok);
    pop_exp(e, ok);
    total_cnt++; if (!ok || bus.owner !== e.owner || bus.ack !== (4'b0001 << e.owner) || bus.q !== e.data)
      $display("FAIL wrap_second: got owner %0d ack %b q %h want owner %0d q %h", bus.owner, bus.ack, bus.q, e.owner, e.data); else pass_cnt++;
    bus.req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_withdraw;
    bit ok;
    wd[1] = 4'hF;
    bus.req = 4'b0010;
    @(negedge clk);
    total_cnt++; if (bus.busy !== 1'b1 || bus.owner !== 2'd1 || bus.ack !== 4'b0000)
      $display("FAIL withdraw_grant: got busy %b owner %0d ack %b want 1 1 0000", bus.busy, bus.owner, bus.ack); else pass_cnt++;
    bus.req = 4'b0000;
    @(negedge clk);
    total_cnt++; if (bus.busy !== 1'b0 || bus.ack !== 4'b0000 || bus.q !== 4'h9)
      $display("FAIL withdraw_idle: got busy %b ack %b q %h want 0 0000 9", bus.busy, bus.ack, bus.q); else pass_cnt++;
    wd[0] = 4'h2; wd[2] = 4'hC;
    bus.req = 4'b0101;
    sb.push_back('{owner: 2'd0, data: 4'h2});
    wait_ack(ok);
    pop_exp(e, ok);
    total_cnt++; if (!ok || bus.owner !== e.owner || bus.q !== e.data)
      $display("FAIL withdraw_next: got owner %0d q %h want owner %0d q %h", bus.owner, bus.q, e.owner, e.data); else pass_cnt++;
    bus.req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op;
    bit ok;
    wd[3] = 4'h6;
    bus.req = 4'b1000;
    sb.push_back('{owner: 2'd3, data: 4'h6});
    wait_ack(ok);
    pop_exp(e, ok);
    total_cnt++; if (!ok || bus.ack !== 4'b1000 || bus.q !== e.data)
      $display("FAIL midrst_setup: got ack %b q %h want 1000 %h", bus.ack, bus.q, e.data); else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    total_cnt++; if (bus.ack !== 4'b0000 || bus.q !== 4'h0 || bus.busy !== 1'b0 || bus.owner !== 2'd0)
      $display("FAIL midrst_async: got ack %b q %h busy %b owner %0d want 0000 0 0 0", bus.ack, bus.q, bus.busy, bus.owner); else pass_cnt++;
    bus.req = 4'b0000;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst = 1'b0;
    bus.req = 4'b0000;
    for (int i = 0; i < 4; i++) wd[i] = 4'h0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_wrap();
    test_withdraw();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
